// File: rtl/mem_responder_pkg.sv
// Shared encodings, FSM state enum, defaults and request payload for mem_responder.
package mem_responder_pkg;

  localparam int unsigned DEPTH_WORDS_DEF = 256;
  localparam int unsigned WAIT_STATES_DEF = 2;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned SIZE_W          = 2;
  localparam int unsigned CNT_W           = 4;

  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Initiator/responder bus for mem_responder.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [SIZE_W-1:0] size;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, size, wdata, input busy, ack, rdata, err);
  modport slave  (input req, we, addr, size, wdata, output busy, ack, rdata, err);
endinterface

// File: rtl/mem_lane_merge.sv
// Little-endian lane extraction and write merge for byte/half/word accesses.
module mem_lane_merge
  import mem_responder_pkg::*;
(
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_off,
  input  logic [SIZE_W-1:0] i_size,
  output logic [DATA_W-1:0] o_merged_c,
  output logic [DATA_W-1:0] o_rd_c
);

  always_comb begin
    o_merged_c = i_old;
    o_rd_c     = '0;
    case (i_size)
      SZ_BYTE: begin
        o_merged_c[{i_off, 3'b000} +: 8] = i_wdata[7:0];
        o_rd_c = {24'b0, i_old[{i_off, 3'b000} +: 8]};
      end
      SZ_HALF: begin
        o_merged_c[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
        o_rd_c = {16'b0, i_old[{i_off[1], 4'b0000} +: 16]};
      end
      default: begin
        o_merged_c = i_wdata;
        o_rd_c     = i_old;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder with one-cycle ack; reset-immune storage.
// Optional alignment errors via MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEF
) (
  input logic            clk,
  input logic            rst_n,
  mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  req_t               r_req;
  logic               r_busy, r_ack, r_err;
  logic [DATA_W-1:0]  r_rdata;
  logic               w_capture, w_busy_nxt, w_ack_nxt, w_err_nxt, w_wr_en;
  logic [DATA_W-1:0]  w_rdata_nxt, w_old, w_merged, w_rd;
  logic               w_oob, w_misalign, w_fail;
  logic [IDX_W-1:0]   w_idx;
  logic [DATA_W-1:0]  r_mem [DEPTH_WORDS];

  assign w_idx  = r_req.addr[IDX_W+1:2];
  assign w_oob  = {2'b00, r_req.addr[ADDR_W-1:2]} >= 32'(DEPTH_WORDS);
  assign w_old  = r_mem[w_idx];
  assign w_fail = w_oob | w_misalign;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign w_misalign = ((r_req.size == SZ_HALF) && r_req.addr[0]) ||
                      (r_req.size[1] && (r_req.addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  mem_lane_merge u_lane (
    .i_old      (w_old),
    .i_wdata    (r_req.wdata),
    .i_off      (r_req.addr[1:0]),
    .i_size     (r_req.size),
    .o_merged_c (w_merged),
    .o_rd_c     (w_rd)
  );

  // Next state and registered-output values; the RESP edge commits the access.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = '0;
    w_wr_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_capture = 1'b1;
          if (WAIT_STATES == 0) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_W'(WAIT_STATES) - 4'd1;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) w_state_nxt = RESP;
        else             w_cnt_nxt   = r_cnt - 4'd1;
      end
      RESP: begin
        w_state_nxt = IDLE;
        w_ack_nxt   = 1'b1;
        w_err_nxt   = w_fail;
        w_wr_en     = r_req.we & ~w_fail;
        w_rdata_nxt = (r_req.we | w_fail) ? '0 : w_rd;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
      if (w_capture) begin
        r_req <= '{we: bus.we, addr: bus.addr, size: bus.size, wdata: bus.wdata};
      end
    end
  end

  // Storage deliberately has no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_idx] <= w_merged;
  end

  assign bus.busy  = r_busy;
  assign bus.ack   = r_ack;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level model plus directed literal checks.
module tb_mem_responder;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned WS    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if u_if ();

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: accept when free, answer WS+1 edges later.
  logic [31:0] m_mem [DEPTH];
  bit          m_pend = 1'b0;
  bit          m_ack  = 1'b0;
  bit          m_err  = 1'b0;
  logic [31:0] m_rd   = '0;
  int          m_ack_edge = 0;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_size;

  function automatic bit m_bad(input logic [31:0] a, input logic [1:0] sz);
    if ((a >> 2) >= DEPTH) return 1'b1;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    if (sz == 2'b01 && a[0]) return 1'b1;
    if (sz[1] && a[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int m_shift(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b00) return 8 * int'(a[1:0]);
    if (sz == 2'b01) return 16 * int'(a[1]);
    return 0;
  endfunction

  function automatic logic [31:0] m_mask(input logic [1:0] sz);
    if (sz == 2'b00) return 32'h0000_00FF;
    if (sz == 2'b01) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  always @(posedge clk) begin
    logic [31:0] old, mk;
    int sh;
    cyc++;
    m_ack = 1'b0;
    if (!rst_n) begin
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (cyc == m_ack_edge) begin
        m_pend = 1'b0;
        m_ack  = 1'b1;
        m_err  = m_bad(m_addr, m_size);
        m_rd   = '0;
        if (!m_err) begin
          old = m_mem[m_addr >> 2];
          sh  = m_shift(m_addr, m_size);
          mk  = m_mask(m_size);
          if (m_we) m_mem[m_addr >> 2] = (old & ~(mk << sh)) | ((m_wdata & mk) << sh);
          else      m_rd = (old >> sh) & mk;
        end
      end
    end else if (u_if.req) begin
      m_we = u_if.we; m_addr = u_if.addr; m_size = u_if.size; m_wdata = u_if.wdata;
      m_pend = 1'b1;
      m_ack_edge = cyc + int'(WS) + 1;
    end
  end

  // Per-cycle comparison against the model, plus capture of each response.
  logic [31:0] last_rdata = '0;
  logic        last_err   = 1'b0;
  int          last_ack_cyc = 0;
  int          ack_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy",  32'(u_if.busy), 32'd0);
      chk("rst_ack",   32'(u_if.ack),  32'd0);
      chk("rst_err",   32'(u_if.err),  32'd0);
      chk("rst_rdata", u_if.rdata,     32'd0);
    end else begin
      chk("busy",  32'(u_if.busy), 32'(m_pend));
      chk("ack",   32'(u_if.ack),  32'(m_ack));
      chk("err",   32'(u_if.err),  m_ack ? 32'(m_err) : 32'd0);
      chk("rdata", u_if.rdata,     m_ack ? m_rd : 32'd0);
      if (u_if.ack) begin
        last_rdata   = u_if.rdata;
        last_err     = u_if.err;
        last_ack_cyc = cyc;
        ack_q.push_back(cyc);
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, output int acc);
    @(negedge clk);
    u_if.req = 1'b1; u_if.we = we; u_if.addr = a; u_if.size = sz; u_if.wdata = wd;
    acc = cyc + 1;
    @(negedge clk);
    u_if.req = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic check_resp(input string nm, input int acc, input logic [31:0] rd, input logic er);
    chk({nm, "_lat"}, 32'(last_ack_cyc - acc), 32'd3);
    chk({nm, "_rdata"}, last_rdata, rd);
    chk({nm, "_err"}, 32'(last_err), 32'(er));
  endtask

  initial begin
    int acc, n0;
    u_if.req = 1'b0; u_if.we = 1'b0; u_if.addr = '0; u_if.size = 2'b10; u_if.wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    access(1'b1, 32'h10, 2'b10, 32'hDEAD_BEEF, acc);  check_resp("wr_word", acc, 32'h0, 1'b0);
    access(1'b0, 32'h10, 2'b10, 32'h0, acc);          check_resp("rd_word", acc, 32'hDEAD_BEEF, 1'b0);
    access(1'b1, 32'h11, 2'b00, 32'h0000_00AA, acc);
    access(1'b0, 32'h10, 2'b10, 32'h0, acc);          check_resp("rd_merged", acc, 32'hDEAD_AAEF, 1'b0);
    access(1'b0, 32'h13, 2'b00, 32'h0, acc);          check_resp("rd_byte3", acc, 32'h0000_00DE, 1'b0);
    access(1'b0, 32'h12, 2'b01, 32'h0, acc);          check_resp("rd_half_hi", acc, 32'h0000_DEAD, 1'b0);
    access(1'b0, 32'h11, 2'b01, 32'h0, acc);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    check_resp("rd_half_mis", acc, 32'h0, 1'b1);
`else
    check_resp("rd_half_mis", acc, 32'h0000_AAEF, 1'b0);
`endif

    // Out of range: error, no aliasing onto word 0.
    access(1'b1, 32'h0, 2'b10, 32'h1111_1111, acc);
    access(1'b0, 32'h400, 2'b10, 32'h0, acc);         check_resp("rd_oob", acc, 32'h0, 1'b1);
    access(1'b1, 32'h400, 2'b10, 32'h5555_5555, acc); check_resp("wr_oob", acc, 32'h0, 1'b1);
    access(1'b0, 32'h0, 2'b10, 32'h0, acc);           check_resp("rd_word0", acc, 32'h1111_1111, 1'b0);

    // Size 11 behaves as word; half write lands in upper lanes.
    access(1'b1, 32'h24, 2'b11, 32'hA5A5_5A5A, acc);
    access(1'b1, 32'h26, 2'b01, 32'h0000_BEEF, acc);
    access(1'b0, 32'h24, 2'b10, 32'h0, acc);          check_resp("rd_sz3_half", acc, 32'hBEEF_5A5A, 1'b0);

    // req held high: accepts every WS+2 cycles.
    n0 = ack_q.size();
    @(negedge clk);
    u_if.req = 1'b1; u_if.we = 1'b0; u_if.addr = 32'h10; u_if.size = 2'b10;
    repeat (16) @(negedge clk);
    u_if.req = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_acks", 32'(ack_q.size() - n0), 32'd4);
    for (int i = n0 + 1; i < ack_q.size(); i++) chk("held_spacing", 32'(ack_q[i] - ack_q[i-1]), 32'd4);

    // req pulses while busy are ignored.
    n0 = ack_q.size();
    @(negedge clk); u_if.req = 1'b1;
    @(negedge clk); u_if.req = 1'b1;
    @(negedge clk); u_if.req = 1'b0;
    @(negedge clk); u_if.req = 1'b1;
    @(negedge clk); u_if.req = 1'b0;
    repeat (5) @(negedge clk);
    chk("pulse_acks", 32'(ack_q.size() - n0), 32'd1);

    // Reset during WAIT abandons the write.
    access(1'b1, 32'h20, 2'b10, 32'hCAFE_F00D, acc);
    n0 = ack_q.size();
    @(negedge clk);
    u_if.req = 1'b1; u_if.we = 1'b1; u_if.addr = 32'h20; u_if.size = 2'b10; u_if.wdata = 32'h1234_5678;
    @(negedge clk);
    u_if.req = 1'b0;
    @(posedge clk);
    #1 chk("abort_busy_pre", 32'(u_if.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("abort_busy_now", 32'(u_if.busy), 32'd0);
    chk("abort_ack_now", 32'(u_if.ack), 32'd0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_ack", 32'(ack_q.size() - n0), 32'd0);
    access(1'b0, 32'h20, 2'b10, 32'h0, acc);          check_resp("rd_after_abort", acc, 32'hCAFE_F00D, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
